udp_tx_framer: RTL

Transmit-side UDP framing stage between the UDP TX user interface and the IPv4 TX layer. Accepts a UDP header on `udp_tx_start` plus a byte payload stream, requests an IPv4 transmission with protocol 17, and emits the 8-byte UDP header followed by the payload to the IP layer. Reports per-datagram status on `udp_tx_result`.

---
 rtl/udp_tx_framer_if.sv | 46 ++++
 rtl/udp_tx_framer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/udp_tx_framer_if.sv
// UDP TX framer bus: user-side header/payload and IPv4-side request/stream.
// slave  = framer view, master = environment view (user + IP layer).
interface udp_tx_framer_if;
  // User side
  logic        udp_tx_start;
  logic [31:0] udp_txi_hdr_dst_ip_addr;
  logic [15:0] udp_txi_hdr_dst_port;
  logic [15:0] udp_txi_hdr_src_port;
  logic [15:0] udp_txi_hdr_data_length;
  logic [15:0] udp_txi_hdr_checksum;
  logic [7:0]  udp_txi_data_out;
  logic        udp_txi_data_out_valid;
  logic        udp_txi_data_out_last;
  logic        udp_tx_data_out_ready;
  logic [1:0]  udp_tx_result;
  // IPv4 side
  logic        ip_tx_start;
  logic [7:0]  ip_tx_hdr_protocol;
  logic [15:0] ip_tx_hdr_data_length;
  logic [31:0] ip_tx_hdr_dst_ip_addr;
  logic [7:0]  ip_tx_data_out;
  logic        ip_tx_data_out_valid;
  logic        ip_tx_data_out_last;
  logic [1:0]  ip_tx_result;
  logic        ip_tx_data_out_ready;

  modport slave (
    input  udp_tx_start, udp_txi_hdr_dst_ip_addr, udp_txi_hdr_dst_port,
           udp_txi_hdr_src_port, udp_txi_hdr_data_length, udp_txi_hdr_checksum,
           udp_txi_data_out, udp_txi_data_out_valid, udp_txi_data_out_last,
           ip_tx_result, ip_tx_data_out_ready,
    output udp_tx_data_out_ready, udp_tx_result, ip_tx_start, ip_tx_hdr_protocol,
           ip_tx_hdr_data_length, ip_tx_hdr_dst_ip_addr, ip_tx_data_out,
           ip_tx_data_out_valid, ip_tx_data_out_last
  );

  modport master (
    output udp_tx_start, udp_txi_hdr_dst_ip_addr, udp_txi_hdr_dst_port,
           udp_txi_hdr_src_port, udp_txi_hdr_data_length, udp_txi_hdr_checksum,
           udp_txi_data_out, udp_txi_data_out_valid, udp_txi_data_out_last,
           ip_tx_result, ip_tx_data_out_ready,
    input  udp_tx_data_out_ready, udp_tx_result, ip_tx_start, ip_tx_hdr_protocol,
           ip_tx_hdr_data_length, ip_tx_hdr_dst_ip_addr, ip_tx_data_out,
           ip_tx_data_out_valid, ip_tx_data_out_last
  );
endinterface

// File: rtl/udp_tx_framer.sv
// UDP transmit framer: latches a UDP header, requests an IPv4 send (protocol 17),
// emits the 8-byte UDP header then passes the payload through to the IP layer.
// Optional macro UDP_TX_ZERO_CSUM_EN: transmit the checksum field as zero.
module udp_tx_framer (
  input logic            clk,
  input logic            reset,
  udp_tx_framer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHdr, StPayload, StDrain} state_e;

  state_e      state_q, state_d;
  logic [15:0] src_q, dst_q, len_q, csum_q, ip_len_q;
  logic [31:0] ip_q;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  result_q, result_d;
  logic        start_q;
  logic        accept, ip_err, at_end, in_xfer;
  logic [7:0]  hdr_byte;
  logic [15:0] csum_tx;

  assign accept  = (state_q == StIdle) && bus.udp_tx_start;
  assign ip_err  = (bus.ip_tx_result == 2'b10);
  assign at_end  = (cnt_q == len_q - 16'd1);
  assign in_xfer = bus.udp_txi_data_out_valid && bus.ip_tx_data_out_ready;

`ifdef UDP_TX_ZERO_CSUM_EN
  assign csum_tx = 16'h0000;
`else
  assign csum_tx = csum_q;
`endif

  assign bus.ip_tx_start           = start_q;
  assign bus.ip_tx_hdr_protocol    = 8'h11;
  assign bus.ip_tx_hdr_data_length = ip_len_q;
  assign bus.ip_tx_hdr_dst_ip_addr = ip_q;
  assign bus.udp_tx_result         = result_q;

  // Header byte selected from latched fields; ip_len_q doubles as the UDP length.
  always_comb begin
    hdr_byte = 8'h00;
    unique case (idx_q)
      3'd0: hdr_byte = src_q[15:8];
      3'd1: hdr_byte = src_q[7:0];
      3'd2: hdr_byte = dst_q[15:8];
      3'd3: hdr_byte = dst_q[7:0];
      3'd4: hdr_byte = ip_len_q[15:8];
      3'd5: hdr_byte = ip_len_q[7:0];
      3'd6: hdr_byte = csum_tx[15:8];
      3'd7: hdr_byte = csum_tx[7:0];
    endcase
  end

  // State, counters, result and latched header.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      idx_q    <= 3'd0;
      cnt_q    <= 16'd0;
      result_q <= 2'b00;
      start_q  <= 1'b0;
      src_q    <= 16'd0;
      dst_q    <= 16'd0;
      len_q    <= 16'd0;
      csum_q   <= 16'd0;
      ip_len_q <= 16'd0;
      ip_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      start_q  <= accept;
      if (accept) begin
        src_q    <= bus.udp_txi_hdr_src_port;
        dst_q    <= bus.udp_txi_hdr_dst_port;
        len_q    <= bus.udp_txi_hdr_data_length;
        csum_q   <= bus.udp_txi_hdr_checksum;
        ip_len_q <= bus.udp_txi_hdr_data_length + 16'd8;
        ip_q     <= bus.udp_txi_hdr_dst_ip_addr;
      end
    end
  end

  // Next state and stream outputs.
  always_comb begin
    state_d                   = state_q;
    idx_d                     = idx_q;
    cnt_d                     = cnt_q;
    result_d                  = result_q;
    bus.udp_tx_data_out_ready = 1'b0;
    bus.ip_tx_data_out        = 8'h00;
    bus.ip_tx_data_out_valid  = 1'b0;
    bus.ip_tx_data_out_last   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.udp_tx_start) begin
          state_d  = StHdr;
          idx_d    = 3'd0;
          cnt_d    = 16'd0;
          result_d = 2'b01;
        end
      end
      StHdr: begin
        bus.ip_tx_data_out       = hdr_byte;
        bus.ip_tx_data_out_valid = 1'b1;
        bus.ip_tx_data_out_last  = (idx_q == 3'd7) && (len_q == 16'd0);
        if (ip_err) begin
          state_d  = StIdle;
          result_d = 2'b10;
        end else if (bus.ip_tx_data_out_ready) begin
          if (idx_q == 3'd7) begin
            if (len_q == 16'd0) begin
              state_d  = StIdle;
              result_d = 2'b11;
            end else begin
              state_d = StPayload;
              cnt_d   = 16'd0;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StPayload: begin
        bus.ip_tx_data_out        = bus.udp_txi_data_out;
        bus.ip_tx_data_out_valid  = bus.udp_txi_data_out_valid;
        bus.ip_tx_data_out_last   = bus.udp_txi_data_out_last || at_end;
        bus.udp_tx_data_out_ready = bus.ip_tx_data_out_ready;
        if (ip_err) begin
          state_d  = StIdle;
          result_d = 2'b10;
        end else if (in_xfer) begin
          if (bus.udp_txi_data_out_last) begin
            state_d  = StIdle;
            result_d = at_end ? 2'b11 : 2'b10;
          end else if (at_end) begin
            // Length exhausted but user stream continues: discard the rest.
            state_d  = StDrain;
            result_d = 2'b10;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StDrain: begin
        bus.udp_tx_data_out_ready = 1'b1;
        if (bus.udp_txi_data_out_valid && bus.udp_txi_data_out_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
